// File: rtl/mpmc9_pkg.sv
// Shared types and helpers for the mpmc9 read-cache fill path.
package mpmc9_pkg;

  localparam int MPMC9_NCH = 8;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, ACK} fill_state_t;

  function automatic logic [27:0] line_of(input logic [31:0] adr);
    return adr[31:4];
  endfunction

endpackage

// File: rtl/mpmc9_rr_arb.sv
// Combinational round-robin pick: first requester at or after the rr pointer.
module mpmc9_rr_arb
  import mpmc9_pkg::*;
#(
  parameter int NCH  = MPMC9_NCH,
  parameter int IDXW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] rr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_req
);

  localparam logic [IDXW:0] NCH_W = (IDXW+1)'(NCH);

  logic [IDXW:0] cand;
  logic          found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, rr} + (IDXW+1)'(i);
      if (cand >= NCH_W) cand = cand - NCH_W;
      if (!found && req[cand[IDXW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDXW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mpmc9_cache_fill.sv
// Cache fill controller: arbitrates line misses, fetches lines from memory,
// writes them into the shared read cache and invalidates lines hit by writes.
//
// state | meaning
// IDLE  | no fetch in flight; arbitrate pending misses
// REQ   | mem_rd_req held until mem_rd_gnt
// WAIT  | waiting for mem_rd_valid, timeout counter running
// FILL  | decide: write the line, or refetch if a snoop made it stale
// ACK   | cwr on the bus; acknowledge the channel, advance rr
module mpmc9_cache_fill
  import mpmc9_pkg::*;
#(
  parameter int NCH = MPMC9_NCH,
  parameter int TMO = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    miss_req,
  input  logic [NCH*32-1:0] miss_adr,
  output logic [NCH-1:0]    miss_ack,
  input  logic              snp_wr,
  input  logic [31:0]       snp_adr,
  output logic              mem_rd_req,
  output logic [31:0]       mem_rd_adr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [127:0]      mem_rd_dat,
  output logic              cwr,
  output logic              cinv,
  output logic [31:0]       cadr,
  output logic [127:0]      cdat,
  output logic              busy,
  output logic              tmo_err
);

  localparam int IDXW = $clog2(NCH);
  localparam int TW   = $clog2(TMO + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);
  localparam logic [IDXW-1:0] LAST_CH  = IDXW'(NCH - 1);

  fill_state_t     state_q, state_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] gch_q, gch_d;
  logic [27:0]     line_q, line_d;
  logic            stale_q, stale_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [127:0]    dat_q, dat_d;
  logic            snp_pend_q, snp_pend_d;
  logic [27:0]     snp_line_q, snp_line_d;
  logic [NCH-1:0]  miss_ack_q, miss_ack_d;
  logic            mem_rd_req_q, mem_rd_req_d;
  logic            cwr_q, cwr_d;
  logic            cinv_q, cinv_d;
  logic [31:0]     cadr_q, cadr_d;
  logic [127:0]    cdat_q, cdat_d;
  logic            busy_q, busy_d;
  logic            tmo_err_q, tmo_err_d;

  logic [31:0]     ch_adr [NCH];
  logic [NCH-1:0]  req_elig;
  logic [IDXW-1:0] arb_idx;
  logic            arb_any;
  logic            snp_hit;

  for (genvar n = 0; n < NCH; n++) begin : g_adr
    assign ch_adr[n] = miss_adr[n*32 +: 32];
  end

  // The channel being acked still shows its request this cycle; keep it out
  // of arbitration so it is not refetched before it can drop the request.
  assign req_elig = miss_req & ~miss_ack_q;

  mpmc9_rr_arb #(.NCH(NCH)) u_arb (
    .req     (req_elig),
    .rr      (rr_q),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  assign snp_hit = snp_wr && (line_of(snp_adr) == line_q);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gch_d        = gch_q;
    line_d       = line_q;
    stale_d      = stale_q;
    timer_d      = timer_q;
    dat_d        = dat_q;
    snp_pend_d   = 1'b0;
    snp_line_d   = snp_line_q;
    miss_ack_d   = '0;
    mem_rd_req_d = mem_rd_req_q;
    cwr_d        = 1'b0;
    cinv_d       = 1'b0;
    cadr_d       = cadr_q;
    cdat_d       = cdat_q;
    tmo_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gch_d        = arb_idx;
          line_d       = line_of(ch_adr[arb_idx]);
          stale_d      = 1'b0;
          mem_rd_req_d = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (snp_hit) stale_d = 1'b1;
        if (mem_rd_req_q && mem_rd_gnt) begin
          mem_rd_req_d = 1'b0;
          timer_d      = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (snp_hit) stale_d = 1'b1;
        if (mem_rd_valid) begin
          dat_d   = mem_rd_dat;
          state_d = FILL;
        end else if (timer_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FILL: begin
        if (stale_q || snp_hit) begin
          stale_d      = 1'b0;
          mem_rd_req_d = 1'b1;
          state_d      = REQ;
        end else begin
          cwr_d   = 1'b1;
          cadr_d  = {line_q, 4'h0};
          cdat_d  = dat_q;
          state_d = ACK;
        end
      end
      ACK: begin
        miss_ack_d[gch_q] = miss_req[gch_q];
        rr_d    = (gch_q == LAST_CH) ? '0 : gch_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Invalidates share cadr with the line write, so a snoop that lands on a
    // cwr slot is parked for one cycle.
    if (snp_pend_q) begin
      cinv_d = 1'b1;
      cadr_d = {snp_line_q, 4'h0};
    end
    if (snp_wr) begin
      if (cwr_d || snp_pend_q) begin
        snp_pend_d = 1'b1;
        snp_line_d = line_of(snp_adr);
      end else begin
        cinv_d = 1'b1;
        cadr_d = {line_of(snp_adr), 4'h0};
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      gch_q        <= '0;
      line_q       <= '0;
      stale_q      <= 1'b0;
      timer_q      <= '0;
      dat_q        <= '0;
      snp_pend_q   <= 1'b0;
      snp_line_q   <= '0;
      miss_ack_q   <= '0;
      mem_rd_req_q <= 1'b0;
      cwr_q        <= 1'b0;
      cinv_q       <= 1'b0;
      cadr_q       <= '0;
      cdat_q       <= '0;
      busy_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gch_q        <= gch_d;
      line_q       <= line_d;
      stale_q      <= stale_d;
      timer_q      <= timer_d;
      dat_q        <= dat_d;
      snp_pend_q   <= snp_pend_d;
      snp_line_q   <= snp_line_d;
      miss_ack_q   <= miss_ack_d;
      mem_rd_req_q <= mem_rd_req_d;
      cwr_q        <= cwr_d;
      cinv_q       <= cinv_d;
      cadr_q       <= cadr_d;
      cdat_q       <= cdat_d;
      busy_q       <= busy_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign miss_ack   = miss_ack_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_rd_adr = {line_q, 4'h0};
  assign cwr        = cwr_q;
  assign cinv       = cinv_q;
  assign cadr       = cadr_q;
  assign cdat       = cdat_q;
  assign busy       = busy_q;
  assign tmo_err    = tmo_err_q;

  // A parked snoop always drains next cycle because a line write is never
  // followed directly by another.
  a_pend_drains: assert property (@(posedge clk) disable iff (rst)
    snp_pend_q |-> !cwr_d);
  a_cwr_cinv_excl: assert property (@(posedge clk) disable iff (rst)
    !(cwr_q && cinv_q));

endmodule

// File: tb/tb_mpmc9_cache_fill.sv
// Directed bench for mpmc9_cache_fill (TMO shortened to 16).
module tb_mpmc9_cache_fill;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   miss_req;
  logic [255:0] miss_adr;
  logic [7:0]   miss_ack;
  logic         snp_wr;
  logic [31:0]  snp_adr;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_adr;
  logic         mem_rd_gnt;
  logic         mem_rd_valid;
  logic [127:0] mem_rd_dat;
  logic         cwr;
  logic         cinv;
  logic [31:0]  cadr;
  logic [127:0] cdat;
  logic         busy;
  logic         tmo_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mpmc9_cache_fill #(.NCH(8), .TMO(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_adr     (miss_adr),
    .miss_ack     (miss_ack),
    .snp_wr       (snp_wr),
    .snp_adr      (snp_adr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_adr   (mem_rd_adr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_dat   (mem_rd_dat),
    .cwr          (cwr),
    .cinv         (cinv),
    .cadr         (cadr),
    .cdat         (cdat),
    .busy         (busy),
    .tmo_err      (tmo_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("cwr_cinv_excl", 128'(cwr & cinv), 128'h0);
  endtask

  task automatic set_req(input int ch, input logic [31:0] adr);
    miss_adr[ch*32 +: 32] = adr;
    miss_req[ch] = 1'b1;
  endtask

  // Serves one fetch with immediate gnt and valid; returns the ack vector.
  task automatic fetch(input logic [31:0] exp_adr, input logic [127:0] dat,
                       output logic [7:0] ack);
    int n = 0;
    while (mem_rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_req", 128'(mem_rd_req), 128'h1);
    chk("fetch_rd_adr", 128'(mem_rd_adr), 128'(exp_adr));
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_dat   = dat;
    tick();
    mem_rd_valid = 1'b0;
    tick();
    chk("fetch_cwr", 128'(cwr), 128'h1);
    chk("fetch_cadr", 128'(cadr), 128'(exp_adr));
    chk("fetch_cdat", cdat, dat);
    tick();
    ack = miss_ack;
    miss_req = miss_req & ~miss_ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ack;
    rst = 1'b1; miss_req = '0; miss_adr = '0; snp_wr = 1'b0; snp_adr = '0;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_dat = '0;
    repeat (3) tick();
    chk("reset_ctl", 128'({miss_ack, mem_rd_req, cwr, cinv, busy, tmo_err}), 128'h0);
    chk("reset_adr", 128'({mem_rd_adr, cadr}), 128'h0);
    chk("reset_cdat", cdat, 128'h0);
    rst = 1'b0;
    tick();

    // Single miss, ch3, valid a few cycles into WAIT
    set_req(3, 32'h0001_2340);
    mem_rd_gnt = 1'b1;
    tick();
    chk("single_req", 128'(mem_rd_req), 128'h1);
    chk("single_rd_adr", 128'(mem_rd_adr), 128'h0001_2340);
    chk("single_busy", 128'(busy), 128'h1);
    tick();
    chk("single_req_drop", 128'(mem_rd_req), 128'h0);
    repeat (3) tick();
    mem_rd_valid = 1'b1;
    mem_rd_dat   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    tick();
    mem_rd_valid = 1'b0;
    chk("single_no_cwr_yet", 128'(cwr), 128'h0);
    tick();
    chk("single_cwr", 128'(cwr), 128'h1);
    chk("single_cadr", 128'(cadr), 128'h0001_2340);
    chk("single_cdat", cdat, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    chk("single_ack_not_yet", 128'(miss_ack), 128'h0);
    tick();
    chk("single_ack", 128'(miss_ack), 128'h08);
    chk("single_cwr_done", 128'(cwr), 128'h0);
    miss_req[3] = 1'b0;
    tick();
    chk("single_ack_pulse", 128'(miss_ack), 128'h0);
    chk("single_idle", 128'(busy), 128'h0);

    // Fairness from rr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 32'h0000_1000);
    set_req(5, 32'h0000_5000);
    set_req(7, 32'h0000_7000);
    fetch(32'h0000_1000, 128'hA0, ack);
    chk("rr_first_ch0", 128'(ack), 128'h01);
    set_req(0, 32'h0000_1000);
    fetch(32'h0000_5000, 128'hA5, ack);
    chk("rr_then_ch5", 128'(ack), 128'h20);
    fetch(32'h0000_7000, 128'hA7, ack);
    chk("rr_then_ch7", 128'(ack), 128'h80);
    fetch(32'h0000_1000, 128'hB0, ack);
    chk("rr_ch0_again", 128'(ack), 128'h01);
    tick();

    // Stale: snoop to the same line during WAIT forces a refetch
    set_req(3, 32'h0001_2340);
    tick();
    tick();
    snp_wr  = 1'b1;
    snp_adr = 32'h0001_234C;
    tick();
    snp_wr = 1'b0;
    chk("stale_cinv", 128'(cinv), 128'h1);
    chk("stale_cinv_adr", 128'(cadr), 128'h0001_2340);
    mem_rd_valid = 1'b1;
    mem_rd_dat   = 128'hDEAD_0001;
    tick();
    mem_rd_valid = 1'b0;
    chk("stale_cinv_pulse", 128'(cinv), 128'h0);
    tick();
    chk("stale_no_cwr", 128'(cwr), 128'h0);
    chk("stale_reissue", 128'(mem_rd_req), 128'h1);
    fetch(32'h0001_2340, 128'hBEEF_0002, ack);
    chk("stale_ack", 128'(ack), 128'h08);
    tick();
    chk("stale_single_ack", 128'(miss_ack), 128'h0);

    // Collision: unrelated snoop in the cycle before cwr is parked
    set_req(1, 32'h0000_0040);
    tick();
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_dat   = 128'hC0C0;
    tick();
    mem_rd_valid = 1'b0;
    snp_wr  = 1'b1;
    snp_adr = 32'h8000_0009;
    tick();
    snp_wr = 1'b0;
    chk("coll_cwr", 128'(cwr), 128'h1);
    chk("coll_no_cinv", 128'(cinv), 128'h0);
    chk("coll_cwr_adr", 128'(cadr), 128'h40);
    tick();
    chk("coll_cinv", 128'(cinv), 128'h1);
    chk("coll_cinv_adr", 128'(cadr), 128'h8000_0000);
    chk("coll_ack", 128'(miss_ack), 128'h02);
    miss_req[1] = 1'b0;
    tick();
    chk("coll_cinv_pulse", 128'(cinv), 128'h0);

    // Timeout after 16 cycles in WAIT, then re-grant of the same channel
    set_req(6, 32'h0000_6000);
    tick();
    tick();
    repeat (15) tick();
    chk("tmo_not_yet", 128'(tmo_err), 128'h0);
    tick();
    chk("tmo_pulse", 128'(tmo_err), 128'h1);
    chk("tmo_idle", 128'(busy), 128'h0);
    chk("tmo_no_ack", 128'(miss_ack), 128'h0);
    fetch(32'h0000_6000, 128'h6666, ack);
    chk("tmo_refetch_ack", 128'(ack), 128'h40);
    tick();

    // Async reset in WAIT; stale memory data must not be written
    set_req(4, 32'h0000_4440);
    tick();
    tick();
    chk("rstw_busy", 128'(busy), 128'h1);
    rst = 1'b1;
    #1;
    chk("rstw_ctl", 128'({miss_ack, mem_rd_req, cwr, cinv, busy, tmo_err}), 128'h0);
    chk("rstw_cdat", cdat, 128'h0);
    chk("rstw_adr", 128'({mem_rd_adr, cadr}), 128'h0);
    tick();
    rst = 1'b0;
    mem_rd_gnt = 1'b0;
    tick();
    chk("rstw_rereq", 128'(mem_rd_req), 128'h1);
    mem_rd_valid = 1'b1;
    mem_rd_dat   = 128'h0BAD;
    tick();
    mem_rd_valid = 1'b0;
    chk("rstw_late_no_cwr", 128'(cwr), 128'h0);
    tick();
    chk("rstw_late_no_cwr2", 128'(cwr), 128'h0);
    chk("rstw_no_ack", 128'(miss_ack), 128'h0);
    mem_rd_gnt = 1'b1;
    fetch(32'h0000_4440, 128'h4444, ack);
    chk("rstw_final_ack", 128'(ack), 128'h10);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpmc9_cache_fill.md
Name: mpmc9_cache_fill

Overview:
- Write-side controller for the mpmc9 shared read cache (1024 lines x 128 bits, direct-mapped, index adr[13:4], tag adr[31:4]).
- Takes line-miss requests from the 8 read channels and arbitrates them round-robin.
- For the granted miss, fetches the 128-bit line from the memory-side read port and writes it into the cache through the cache write/invalidate port.
- Snoops committed memory writes and invalidates matching cache lines, so the cache never returns stale data.

Parameters:
NCH, 8, number of read channels.
TMO, 255, cycles to wait in WAIT for mem_rd_valid before abandoning the fetch.

Ports:
clk  in  1  sole clock; cache write port and memory port are synchronous to it.
rst  in  1  asynchronous, active-high reset.
miss_req  in  NCH  per-channel line-miss request; level, held until miss_ack.
miss_adr  in  NCH*32  per-channel miss address; channel n at [n*32+:32]; bits [3:0] ignored.
miss_ack  out  NCH  one-cycle pulse: line for channel n now valid in cache.
snp_wr  in  1  memory write committed this cycle.
snp_adr  in  32  address of the committed write.
mem_rd_req  out  1  line read request to memory.
mem_rd_adr  out  32  line-aligned read address; [3:0]=0.
mem_rd_gnt  in  1  request accepted; handshake completes when mem_rd_req & mem_rd_gnt.
mem_rd_valid  in  1  read data valid, one cycle.
mem_rd_dat  in  128  read data.
cwr  out  1  cache line write strobe.
cinv  out  1  cache line invalidate strobe; never asserted together with cwr.
cadr  out  32  cache write/invalidate address.
cdat  out  128  cache write data.
busy  out  1  state != IDLE.
tmo_err  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; stale, snp_pend, timer cleared.
- All outputs are registered.
- IDLE: if any miss_req is set, the arbiter picks the first requesting channel at or after rr.
  - Latch gch, the line address (miss_adr[31:4]) and clear stale.
  - Next cycle: state REQ, mem_rd_req=1.
- REQ: hold mem_rd_req and mem_rd_adr stable until gnt.
  - On req & gnt: state WAIT, mem_rd_req=0 next cycle, timer=0.
- WAIT: on mem_rd_valid, capture mem_rd_dat and go to FILL.
  - Otherwise increment the timer.
  - timer==TMO: pulse tmo_err, go to IDLE, no ack; rr is not advanced, so the channel re-arbitrates.
- FILL: one cycle.
  - If not stale: cwr=1, cadr=line, cdat=captured data; go to ACK.
  - If stale: no write; go to REQ and reissue the same line.
- ACK: miss_ack[gch]=1 for one cycle, only if miss_req[gch] is still high.
  - rr = gch+1 mod NCH; go to IDLE.
  - Ack is one cycle after cwr so a channel's next cache lookup hits.
- Minimum miss latency: grant-cycle+1 to cwr when gnt and valid are immediate; ack follows cwr by 1.
- Snoop:
  - snp_wr with snp_adr[31:4]==line while in REQ/WAIT/FILL sets stale.
  - A snoop in FILL itself suppresses that cycle's write.
  - Every snp_wr produces one cinv pulse with cadr=snp_adr, bits [3:0] zeroed.
  - cinv is issued the cycle after snp_wr unless cwr is asserted that cycle.
  - If cwr is asserted, the snoop is held in a one-deep snp_pend register and issued the following cycle.
- Back-to-back snoops while snp_pend is full cannot occur; the next cycle is never cwr, so pend drains in 1 cycle. Assert this in sim.
- Request withdrawn mid-fetch: fetch and fill still complete (harmless), ack suppressed.
- Async reset mid-operation: immediate return to IDLE, outputs 0; an outstanding memory read result is ignored until the next granted request.

Decomposition:
- mpmc9_pkg gains:
  - typedef enum fill_state_t {IDLE, REQ, WAIT, FILL, ACK}
  - constant MPMC9_NCH = 8
  - function line_of(adr) returning adr[31:4]
- Sub-module mpmc9_rr_arb:
  - Combinational NCH-way round-robin pick from req vector and rr pointer.
  - Outputs grant index and any_req.

Test Plan:
- Single miss: ch3 req adr 0x0001_2340, gnt same cycle, valid 4 cycles later with data D → mem_rd_adr=0x0001_2340; cwr with cadr=0x0001_2340, cdat=D; miss_ack=8'h08 one cycle after cwr.
- Fairness: ch0, ch5 and ch7 requesting together, rr=0 → acks in order ch0, ch5, ch7; then with ch0 re-requesting → ch0 is served only after ch7.
- Stale: snp_wr adr 0x0001_234C during WAIT for line 0x0001_234 → no cwr on first return; cinv cadr=0x0001_2340; second mem_rd_req issued; cwr on the second return; single ack.
- Collision: snp_wr (adr 0x8000_0000) in the cycle before cwr → cwr first, cinv cadr=0x8000_0000 next cycle, never both high.
- Timeout: TMO=16, no mem_rd_valid → tmo_err pulse 16 cycles after entering WAIT, busy=0; ch still requesting → re-granted and refetched.
- Reset in WAIT: assert rst → all outputs 0 immediately; late mem_rd_valid produces no cwr and no ack.
